tse_pcs_config_controller: RTL

- Sequences the SGMII PCS register port of the triple-speed Ethernet converter (reg_addr/reg_rd/reg_wr/reg_data_in/reg_data_out/reg_busy), which is currently tied idle.
- After reset it programs SGMII mode and the link timer, then issues a self-clearing PCS soft reset with auto-negotiation enabled.
- It then polls link status and partner ability periodically and exports link, speed and duplex to the top level and to fpga_core.
- Runs in the 125 MHz reference clock domain, the same clock that drives the converter's clk input.

---
 rtl/tse_pcs_pkg.sv | 48 ++++
 rtl/tse_pcs_reg_access.sv | 105 ++++++++++
 rtl/tse_pcs_config_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/tse_pcs_pkg.sv
// Shared definitions for the SGMII PCS configuration controller:
// register map, field positions, speed codes and sequencer states.
package tse_pcs_pkg;

  localparam logic [4:0] ADDR_CONTROL      = 5'h00;
  localparam logic [4:0] ADDR_STATUS       = 5'h01;
  localparam logic [4:0] ADDR_PARTNER      = 5'h05;
  localparam logic [4:0] ADDR_LINK_TIMER_0 = 5'h12;
  localparam logic [4:0] ADDR_LINK_TIMER_1 = 5'h13;
  localparam logic [4:0] ADDR_IF_MODE      = 5'h14;

  localparam int CTRL_RESET_BIT     = 15;
  localparam int STATUS_LINK_BIT    = 2;
  localparam int STATUS_AN_DONE_BIT = 5;
  localparam int PARTNER_DUPLEX_BIT = 12;
  localparam int PARTNER_SPEED_LSB  = 10;

  // SGMII_ENA | USE_SGMII_AN
  localparam logic [15:0] IF_MODE_SGMII = 16'h0003;
  // soft reset, AN enable, full duplex, 1000M
  localparam logic [15:0] CTRL_INIT     = 16'h9140;

  typedef enum logic [1:0] {
    SPEED_10   = 2'b00,
    SPEED_100  = 2'b01,
    SPEED_1000 = 2'b10,
    SPEED_RSVD = 2'b11
  } speed_e;

  typedef enum logic [3:0] {
    ST_WAIT_INIT,
    ST_W_IFMODE,
    ST_W_LT0,
    ST_W_LT1,
    ST_W_CTRL,
    ST_R_CTRL,
    ST_POLL_WAIT,
    ST_R_STATUS,
    ST_R_PARTNER,
    ST_FAULT
  } pcs_state_e;

  function automatic logic is_access_state(pcs_state_e s);
    return s inside {ST_W_IFMODE, ST_W_LT0, ST_W_LT1, ST_W_CTRL,
                     ST_R_CTRL, ST_R_STATUS, ST_R_PARTNER};
  endfunction

endpackage

// File: rtl/tse_pcs_reg_access.sv
// Single-access engine for the PCS register port: wait-request handshake,
// read-data capture and stall timeout. One command in, one done/timeout out.
module tse_pcs_reg_access
  import tse_pcs_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rd,
  input  logic [4:0]  addr,
  input  logic [15:0] wdata,
  output logic        done,
  output logic        timeout,
  output logic        active,
  output logic [15:0] rdata,
  output logic [4:0]  o_reg_addr,
  output logic        o_reg_rd,
  output logic        o_reg_wr,
  output logic [15:0] o_reg_data_in,
  input  logic [15:0] i_reg_data_out,
  input  logic        i_reg_busy
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  logic          active_q, active_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [4:0]    addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d, timeout_q, timeout_d;

  always_comb begin
    active_d  = active_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        rd_d     = rd;
        wr_d     = !rd;
        addr_d   = addr;
        wdata_d  = wdata;
        cnt_d    = '0;
      end
    end else if (!i_reg_busy) begin
      // completion cycle: request drops next cycle, giving the idle gap
      active_d = 1'b0;
      rd_d     = 1'b0;
      wr_d     = 1'b0;
      done_d   = 1'b1;
      if (rd_q) rdata_d = i_reg_data_out;
    end else if (cnt_q == TW'(TIMEOUT_TICKS - 1)) begin
      active_d  = 1'b0;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      timeout_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q  <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign done          = done_q;
  assign timeout       = timeout_q;
  assign active        = active_q;
  assign rdata         = rdata_q;
  assign o_reg_addr    = addr_q;
  assign o_reg_rd      = rd_q;
  assign o_reg_wr      = wr_q;
  assign o_reg_data_in = wdata_q;

endmodule

// File: rtl/tse_pcs_config_controller.sv
// SGMII PCS configuration/poll sequencer for the triple-speed Ethernet converter.
// Define TSE_PCS_CONFIG_CONTROLLER_LED_EN to drive o_led from registered status.
module tse_pcs_config_controller
  import tse_pcs_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY      = 125000000,
  parameter int unsigned INIT_DELAY_TICKS     = 1000,
  parameter int unsigned POLL_PERIOD_TICKS    = CLOCK_FREQUENCY / 1000,
  parameter int unsigned ACCESS_TIMEOUT_TICKS = 1024,
  parameter int unsigned LINK_TIMER_VALUE     = 200000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_restart,
  output logic [4:0]  o_reg_addr,
  output logic        o_reg_rd,
  output logic        o_reg_wr,
  output logic [15:0] o_reg_data_in,
  input  logic [15:0] i_reg_data_out,
  input  logic        i_reg_busy,
  output logic        o_config_done,
  output logic        o_link_up,
  output logic        o_an_complete,
  output logic [1:0]  o_speed,
  output logic        o_full_duplex,
  output logic        o_error,
  output logic [3:0]  o_led
);

  localparam logic [20:0] LT = 21'(LINK_TIMER_VALUE);

  pcs_state_e  state_q;
  logic [31:0] cnt_q;
  logic [5:0]  ctrl_reads_q;
  logic        issued_q, restart_pend_q;
  logic        config_done_q, error_q, link_up_q, an_complete_q, full_duplex_q;
  speed_e      speed_q;

  logic        acc_start, cmd_rd, acc_done, acc_timeout, acc_active;
  logic [4:0]  cmd_addr;
  logic [15:0] cmd_wdata, acc_rdata;
  logic [1:0]  partner_speed;

  always_comb begin
    cmd_rd    = 1'b0;
    cmd_addr  = ADDR_CONTROL;
    cmd_wdata = '0;
    case (state_q)
      ST_W_IFMODE:  begin cmd_addr = ADDR_IF_MODE;      cmd_wdata = IF_MODE_SGMII; end
      ST_W_LT0:     begin cmd_addr = ADDR_LINK_TIMER_0; cmd_wdata = LT[15:0]; end
      ST_W_LT1:     begin cmd_addr = ADDR_LINK_TIMER_1; cmd_wdata = {11'b0, LT[20:16]}; end
      ST_W_CTRL:    begin cmd_addr = ADDR_CONTROL;      cmd_wdata = CTRL_INIT; end
      ST_R_CTRL:    begin cmd_rd = 1'b1; cmd_addr = ADDR_CONTROL; end
      ST_R_STATUS:  begin cmd_rd = 1'b1; cmd_addr = ADDR_STATUS; end
      ST_R_PARTNER: begin cmd_rd = 1'b1; cmd_addr = ADDR_PARTNER; end
      default: ;
    endcase
    // a pending restart blocks new commands so it can act between accesses
    acc_start = is_access_state(state_q) && !issued_q && !restart_pend_q;
  end

  assign partner_speed = acc_rdata[PARTNER_SPEED_LSB +: 2];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= ST_WAIT_INIT;
      cnt_q          <= '0;
      ctrl_reads_q   <= '0;
      issued_q       <= 1'b0;
      restart_pend_q <= 1'b0;
      config_done_q  <= 1'b0;
      error_q        <= 1'b0;
      link_up_q      <= 1'b0;
      an_complete_q  <= 1'b0;
      full_duplex_q  <= 1'b0;
      speed_q        <= SPEED_10;
    end else begin
      if (i_restart) restart_pend_q <= 1'b1;
      if (restart_pend_q && !acc_active) begin
        restart_pend_q <= i_restart;
        state_q        <= ST_W_IFMODE;
        cnt_q          <= '0;
        ctrl_reads_q   <= '0;
        issued_q       <= 1'b0;
        config_done_q  <= 1'b0;
        error_q        <= 1'b0;
        link_up_q      <= 1'b0;
        an_complete_q  <= 1'b0;
      end else begin
        if (acc_start) issued_q <= 1'b1;
        case (state_q)
          ST_WAIT_INIT:
            if (cnt_q == 32'(INIT_DELAY_TICKS - 1)) state_q <= ST_W_IFMODE;
            else cnt_q <= cnt_q + 1'b1;
          ST_POLL_WAIT:
            if (cnt_q == 32'(POLL_PERIOD_TICKS - 1)) state_q <= ST_R_STATUS;
            else cnt_q <= cnt_q + 1'b1;
          ST_FAULT: ;
          default:
            if (acc_timeout) begin
              error_q       <= 1'b1;
              config_done_q <= 1'b0;
              state_q       <= ST_FAULT;
            end else if (acc_done) begin
              issued_q <= 1'b0;
              case (state_q)
                ST_W_IFMODE: state_q <= ST_W_LT0;
                ST_W_LT0:    state_q <= ST_W_LT1;
                ST_W_LT1:    state_q <= ST_W_CTRL;
                ST_W_CTRL: begin
                  ctrl_reads_q <= '0;
                  state_q      <= ST_R_CTRL;
                end
                ST_R_CTRL:
                  if (!acc_rdata[CTRL_RESET_BIT]) begin
                    config_done_q <= 1'b1;
                    cnt_q         <= '0;
                    state_q       <= ST_POLL_WAIT;
                  end else if (ctrl_reads_q == 6'd63) begin
                    error_q <= 1'b1;
                    state_q <= ST_FAULT;
                  end else begin
                    ctrl_reads_q <= ctrl_reads_q + 1'b1;
                  end
                ST_R_STATUS: begin
                  link_up_q     <= acc_rdata[STATUS_LINK_BIT];
                  an_complete_q <= acc_rdata[STATUS_AN_DONE_BIT];
                  state_q       <= ST_R_PARTNER;
                end
                ST_R_PARTNER: begin
                  if (partner_speed != SPEED_RSVD) speed_q <= speed_e'(partner_speed);
                  full_duplex_q <= acc_rdata[PARTNER_DUPLEX_BIT];
                  cnt_q         <= '0;
                  state_q       <= ST_POLL_WAIT;
                end
                default: ;
              endcase
            end
        endcase
      end
    end
  end

  tse_pcs_reg_access #(.TIMEOUT_TICKS(ACCESS_TIMEOUT_TICKS)) u_acc (
    .clk            (i_clock),
    .rst            (i_reset),
    .start          (acc_start),
    .rd             (cmd_rd),
    .addr           (cmd_addr),
    .wdata          (cmd_wdata),
    .done           (acc_done),
    .timeout        (acc_timeout),
    .active         (acc_active),
    .rdata          (acc_rdata),
    .o_reg_addr     (o_reg_addr),
    .o_reg_rd       (o_reg_rd),
    .o_reg_wr       (o_reg_wr),
    .o_reg_data_in  (o_reg_data_in),
    .i_reg_data_out (i_reg_data_out),
    .i_reg_busy     (i_reg_busy)
  );

  assign o_config_done = config_done_q;
  assign o_link_up     = link_up_q;
  assign o_an_complete = an_complete_q;
  assign o_speed       = speed_q;
  assign o_full_duplex = full_duplex_q;
  assign o_error       = error_q;

`ifdef TSE_PCS_CONFIG_CONTROLLER_LED_EN
  logic [3:0] led_q;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) led_q <= '0;
    else         led_q <= {error_q, speed_q == SPEED_1000, an_complete_q, link_up_q};
  end
  assign o_led = led_q;
`else
  assign o_led = 4'b0000;
`endif

endmodule
